// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock.
//
// Parameters
//   W          operand / result width in bits (W >= 2)
//   SIGNED_EN  1: signed_op selects two's-complement division
//              0: signed_op is ignored, every operation is unsigned
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   start      request a division (sampled only while ready=1)
//   signed_op  1 = operands are two's complement (sampled with start)
//   dvnd       dividend (sampled with start)
//   dvsr       divisor  (sampled with start)
//   ready      idle, able to accept start
//   done       one-cycle pulse: quo, rmd and dbz are valid
//   dbz        divide-by-zero flag of the latest completed operation
//   quo        quotient
//   rmd        remainder
//
// Latency: W+2 cycles from the accepting edge to done for a non-zero
// divisor, 1 cycle for a zero divisor. Signed results truncate toward
// zero and the remainder takes the dividend's sign.
module seq_divider #(
  parameter int W         = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         signed_op,
  input  logic [W-1:0] dvnd,
  input  logic [W-1:0] dvsr,
  output logic         ready,
  output logic         done,
  output logic         dbz,
  output logic [W-1:0] quo,
  output logic [W-1:0] rmd
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state_reg, state_next;

  // Working registers: a_reg shifts the dividend magnitude out at the top
  // while quotient bits enter at the bottom; r_reg is the partial remainder.
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W:0]    r_reg;
  logic [CW-1:0] cnt_reg;
  logic          neg_q_reg;
  logic          neg_r_reg;

  // Result registers, only written on entry to DONE.
  logic [W-1:0]  quo_reg;
  logic [W-1:0]  rmd_reg;
  logic          dbz_reg;

  // Operand sign / magnitude at the accepting edge.
  logic          eff_signed;
  logic          dvnd_neg;
  logic          dvsr_neg;
  logic          dvsr_zero;
  logic [W-1:0]  dvnd_mag;
  logic [W-1:0]  dvsr_mag;

  assign eff_signed = SIGNED_EN && signed_op;
  assign dvnd_neg   = eff_signed && dvnd[W-1];
  assign dvsr_neg   = eff_signed && dvsr[W-1];
  assign dvsr_zero  = (dvsr == '0);
  // The magnitude of the most-negative value is 2^(W-1), which still fits
  // in W unsigned bits, so no widening is needed here.
  assign dvnd_mag   = dvnd_neg ? -dvnd : dvnd;
  assign dvsr_mag   = dvsr_neg ? -dvsr : dvsr;

  // One restoring step. The partial remainder is always below the divisor,
  // so the shifted value stays below 2^(W+1); one extra bit on the
  // difference then serves as the borrow.
  logic [W+1:0]  r_shift;
  logic [W+1:0]  diff;
  logic          borrow;

  assign r_shift = {r_reg, a_reg[W-1]};
  assign diff    = r_shift - {2'b00, b_reg};
  assign borrow  = diff[W+1];

  // Sign correction applied when leaving FIX.
  logic [W-1:0]  fix_quo;
  logic [W-1:0]  fix_rmd;

  assign fix_quo = neg_q_reg ? -a_reg : a_reg;
  assign fix_rmd = neg_r_reg ? -r_reg[W-1:0] : r_reg[W-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = dvsr_zero ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt_reg == CW'(1)) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      r_reg     <= '0;
      cnt_reg   <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      quo_reg   <= '0;
      rmd_reg   <= '0;
      dbz_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg     <= dvnd_mag;
            b_reg     <= dvsr_mag;
            r_reg     <= '0;
            cnt_reg   <= CW'(W);
            neg_q_reg <= dvnd_neg ^ dvsr_neg;
            neg_r_reg <= dvnd_neg;
            // A zero divisor goes straight to DONE, so its result is
            // written here, on the edge that enters DONE.
            if (dvsr_zero) begin
              quo_reg <= '1;
              rmd_reg <= dvnd;
              dbz_reg <= 1'b1;
            end
          end
        end
        CALC: begin
          a_reg   <= {a_reg[W-2:0], ~borrow};
          r_reg   <= borrow ? r_shift[W:0] : diff[W:0];
          cnt_reg <= cnt_reg - CW'(1);
        end
        FIX: begin
          quo_reg <= fix_quo;
          rmd_reg <= fix_rmd;
          dbz_reg <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign ready = (state_reg == IDLE);
  assign done  = (state_reg == DONE);
  assign quo   = quo_reg;
  assign rmd   = rmd_reg;
  assign dbz   = dbz_reg;

endmodule
